// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO pair.
// Multiply is shift-add and divide is restoring shift-subtract. Both run on
// operand magnitudes, with the signs fixed up at the final step, so every
// operation takes exactly 32 RUN cycles.
//
// state | meaning
// IDLE  | busy=0, accepts start or MTHI/MTLO writes
// RUN   | busy=1, one radix-2 step per cycle, count 0..31
module mips_muldiv_unit #(
    parameter logic [31:0] DIVZERO_LO = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [5:0]  count;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;
    // work_hi: partial product / partial remainder
    // work_lo: multiplier / dividend shifting into quotient
    logic [31:0] work_hi;
    logic [31:0] work_lo;
    logic [31:0] operand_b;

    logic        s1_in;
    logic        s2_in;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] add_sum;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [63:0] prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Signs are taken only for the signed ops (op[0]==0); magnitudes come from two's-complement negate
    always_comb begin
        s1_in = ~op[0] & src1[31];
        s2_in = ~op[0] & src2[31];
        mag1  = s1_in ? -src1 : src1;
        mag2  = s2_in ? -src2 : src2;
    end

    // One radix-2 step. A divide by zero always subtracts 0, so the remainder ends up holding |src1|.
    always_comb begin
        add_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand_b} : 33'd0);
        shifted = {work_hi, work_lo[31]};
        diff    = shifted - {1'b0, operand_b};
        step_hi = add_sum[32:1];
        step_lo = {add_sum[0], work_lo[31:1]};
        if (is_div) begin
            if (shifted >= {1'b0, operand_b}) begin
                step_hi = diff[31:0];
                step_lo = {work_lo[30:0], 1'b1};
            end else begin
                step_hi = shifted[31:0];
                step_lo = {work_lo[30:0], 1'b0};
            end
        end
    end

    // Sign correction on the values produced by the final step
    always_comb begin
        prod   = neg_res ? -{step_hi, step_lo} : {step_hi, step_lo};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            res_hi = neg_rem ? -step_hi : step_hi;
            res_lo = div_zero ? DIVZERO_LO : (neg_res ? -step_lo : step_lo);
        end
    end

    // Control FSM, datapath registers and the architectural HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            count     <= 6'd0;
            is_div    <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
            work_hi   <= 32'd0;
            work_lo   <= 32'd0;
            operand_b <= 32'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        count     <= 6'd0;
                        is_div    <= op[1];
                        neg_res   <= s1_in ^ s2_in;
                        neg_rem   <= s1_in;
                        div_zero  <= op[1] & (src2 == 32'd0);
                        work_hi   <= 32'd0;
                        work_lo   <= mag1;
                        operand_b <= mag2;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    count   <= count + 6'd1;
                    if (count == 6'd31) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= 6'd0;
                        hi    <= res_hi;
                        lo    <= res_lo;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit for the single-cycle MIPS core. Holds the architectural HI/LO registers.
- Consumes the two ALU operands (rs value, rt value) when the decoder issues MULT/MULTU/DIV/DIVU.
- Runs an iterative radix-2 algorithm and raises busy so the core stalls MFHI/MFLO until the result is ready.
- Also performs MTHI/MTLO writes.

Parameters:
- DIVZERO_LO, 32'hFFFFFFFF, LO value written on any divide with src2 == 0.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue strobe. Accepted only when busy=0.
- op  input  2  operation code, sampled with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src1  input  32  rs operand, sampled with start.
- src2  input  32  rt operand, sampled with start.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  32  MTHI/MTLO data.
- busy  output  1  operation in progress (registered).
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state IDLE, hi=0, lo=0, busy=0, iteration counter=0, any in-flight operation discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, 6-bit counter 0..31.
- IDLE -> RUN on start=1:
  - Latch op and the sign flags s1=src1[31], s2=src2[31] (both forced 0 for MULTU/DIVU).
  - Latch the magnitudes |src1| and |src2| (two's-complement negate when the sign flag is set).
  - Clear counter.
  - busy reads 1 from the next cycle.
- RUN: one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle.
  - At the edge where counter==31, apply sign correction, write hi/lo, and return to IDLE.
  - busy is high for exactly 32 cycles. hi/lo hold the new result in the first cycle busy=0.
- Multiply: 64-bit magnitude product, negated if s1^s2. HI=[63:32], LO=[31:0].
- Divide:
  - Quotient is negated if s1^s2; remainder takes the sign of the dividend (negated if s1). LO=quotient, HI=remainder.
  - src2==0 (detected at start): LO=DIVZERO_LO, HI=src1 unchanged, still 32 cycles.
  - 0x80000000 / 0xFFFFFFFF signed: LO=0x80000000, HI=0 (32-bit wrap, no trap).
- start while busy=1: ignored, no effect on the running operation.
- hi_we/lo_we:
  - When busy=0 and start=0: hi (or lo) <= wdata at the next edge. Both may be asserted together.
  - Ignored while busy=1.
  - Ignored in a cycle where start is accepted (start wins).
- hi/lo change only on completion, MTHI/MTLO, or reset. They hold their value through RUN.
- op values are fully decoded; there are no illegal codes.

Test Plan:
- Reset mid-operation:
  - Reset asserted -> hi=lo=0, busy=0 immediately (asynchronously).
  - Start MULT 3*4, then assert reset at RUN cycle 10 -> busy=0 immediately, hi=lo=0.
  - Next start, 5*6 MULTU -> lo=30, hi=0 after 32 busy cycles.
- Signed vs unsigned multiply, src1=0xFFFFFFFF, src2=0x00000002:
  - MULT -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
  - Each case: busy high exactly 32 cycles after the start cycle.
- Signed division:
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 7/-2 -> lo=0xFFFFFFFD, hi=0x00000001.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero:
  - DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
  - DIV 0xFFFFFFF9/0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF9.
- Handshake:
  - Start MULTU 2*3; during busy pulse start with 9*9 and assert hi_we with wdata=0xDEAD -> result lo=6, hi=0 (both ignored).
  - After completion, MTLO 0x1234 -> lo=0x1234 at the next edge.
  - Assert start and lo_we in the same cycle -> write dropped.
